// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the single-port memory arbiter.
// Holds the FSM state enum, requester port ids and the read-latency legality check.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_D  = 1'b1;

    localparam int unsigned LAT_MIN = 1;
    localparam int unsigned LAT_MAX = 3;

    // True when the RAM read latency fits the 2-bit latency counter.
    function automatic bit lat_ok(input int unsigned lat);
        return (lat >= LAT_MIN) && (lat <= LAT_MAX);
    endfunction

endpackage

// File: rtl/lat_count.sv
// Loadable 2-bit down-counter with registered zero/one flags.
// Ports: clk, rst_n (async active-low), load/load_val (preset), dec (count down,
// saturating at 0), zero/one (count equals 0 / 1).
module lat_count (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [1:0] load_val,
    input  logic       dec,
    output logic       zero,
    output logic       one
);

    logic [1:0] count;

    // Flags are computed from the value being written so they stay registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 2'd0;
            zero  <= 1'b1;
            one   <= 1'b0;
        end else if (load) begin
            count <= load_val;
            zero  <= (load_val == 2'd0);
            one   <= (load_val == 2'd1);
        end else if (dec && (count != 2'd0)) begin
            count <= count - 2'd1;
            zero  <= (count == 2'd1);
            one   <= (count == 2'd2);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between the instruction-fetch port and the data port.
// One transaction outstanding at a time, round-robin on ties, LAT-cycle RAM reads.
// Ports:
//   Clock, Resetn                 clock / async active-low reset
//   if_req, if_addr               fetch request (level) and address
//   if_rdata, if_valid            fetched word and one-cycle completion pulse
//   d_req, d_we, d_addr, d_wdata  data request (level), store flag, address, store data
//   d_rdata, d_valid              load data and one-cycle completion pulse
//   ram_en, ram_we, ram_addr, ram_wdata, ram_rdata   shared synchronous RAM port
//   busy                          high whenever the FSM is not in IDLE
//   err                           sticky out-of-range data address flag
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned DW  = 16,
    parameter int unsigned AW  = 5,
    parameter int unsigned LAT = 1
) (
    input  logic          Clock,
    input  logic          Resetn,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_valid,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [DW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_valid,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    output logic          busy,
    output logic          err
);

    if (!lat_ok(LAT)) begin : g_lat_illegal
        $error("mem_arbiter: LAT must be in 1..3");
    end

    state_t        state, state_n;
    logic          port, port_n;
    logic          last, last_n;
    logic [AW-1:0] addr, addr_n;
    logic [DW-1:0] wdata, wdata_n;
    logic          we, we_n;
    logic          oor, oor_n;
    logic          err_n;
    logic [DW-1:0] if_rdata_n, d_rdata_n;
    logic [DW-1:0] rd_sel;
    logic          pick;
    logic          cnt_load, cnt_dec, cnt_zero, cnt_one;

    lat_count u_lat_count (
        .clk      (Clock),
        .rst_n    (Resetn),
        .load     (cnt_load),
        .load_val (2'(LAT)),
        .dec      (cnt_dec),
        .zero     (cnt_zero),
        .one      (cnt_one)
    );

    // State, grant latches and all registered outputs (derived from next-state values).
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state     <= IDLE;
            port      <= PORT_IF;
            last      <= PORT_D;
            addr      <= '0;
            wdata     <= '0;
            we        <= 1'b0;
            oor       <= 1'b0;
            err       <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            if_valid  <= 1'b0;
            d_valid   <= 1'b0;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            port      <= port_n;
            last      <= last_n;
            addr      <= addr_n;
            wdata     <= wdata_n;
            we        <= we_n;
            oor       <= oor_n;
            err       <= err_n;
            if_rdata  <= if_rdata_n;
            d_rdata   <= d_rdata_n;
            if_valid  <= (state_n == DONE) && (port_n == PORT_IF);
            d_valid   <= (state_n == DONE) && (port_n == PORT_D);
            ram_en    <= (state_n == ISSUE) && !oor_n;
            ram_we    <= (state_n == ISSUE) && we_n && !oor_n;
            ram_addr  <= addr_n;
            ram_wdata <= wdata_n;
            busy      <= (state_n != IDLE);
        end
    end

    // Next-state, grant selection and read-data capture.
    always_comb begin
        state_n    = state;
        port_n     = port;
        last_n     = last;
        addr_n     = addr;
        wdata_n    = wdata;
        we_n       = we;
        oor_n      = oor;
        err_n      = err;
        if_rdata_n = if_rdata;
        d_rdata_n  = d_rdata;
        pick       = PORT_IF;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        // Out-of-range loads return zero regardless of what the RAM port shows.
        rd_sel     = oor ? '0 : ram_rdata;

        case (state)
            IDLE: begin
                if (if_req || d_req) begin
                    if (if_req && d_req) begin
                        pick = ~last;
                    end else begin
                        pick = d_req ? PORT_D : PORT_IF;
                    end
                    port_n  = pick;
                    last_n  = pick;
                    state_n = ISSUE;
                    if (pick == PORT_D) begin
                        addr_n  = d_addr[AW-1:0];
                        wdata_n = d_wdata;
                        we_n    = d_we;
                        oor_n   = |d_addr[DW-1:AW];
                        err_n   = err | oor_n;
                    end else begin
                        addr_n  = if_addr;
                        wdata_n = '0;
                        we_n    = 1'b0;
                        oor_n   = 1'b0;
                    end
                end
            end
            ISSUE: begin
                if (we) begin
                    state_n = DONE;
                end else begin
                    cnt_load = 1'b1;
                    state_n  = WAIT;
                end
            end
            WAIT: begin
                cnt_dec = 1'b1;
                // zero is unreachable here in practice; treated as "data ready" so WAIT cannot hang.
                if (cnt_one || cnt_zero) begin
                    if (port == PORT_IF) begin
                        if_rdata_n = rd_sel;
                    end else begin
                        d_rdata_n = rd_sel;
                    end
                    state_n = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a LAT=1 instance (a_*) and a LAT=3 instance (b_*).
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    typedef struct packed {
        logic        port;
        logic        chk;
        logic [15:0] data;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- instance A, LAT=1 ----------------
    logic        a_rstn, a_if_req, a_d_req, a_d_we, a_if_valid, a_d_valid;
    logic [4:0]  a_if_addr, a_ram_addr;
    logic [15:0] a_d_addr, a_d_wdata, a_if_rdata, a_d_rdata, a_ram_wdata, a_ram_rdata;
    logic        a_ram_en, a_ram_we, a_busy, a_err;

    mem_arbiter #(.DW(16), .AW(5), .LAT(1)) u_dut_a (
        .Clock(clk), .Resetn(a_rstn),
        .if_req(a_if_req), .if_addr(a_if_addr), .if_rdata(a_if_rdata), .if_valid(a_if_valid),
        .d_req(a_d_req), .d_we(a_d_we), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
        .d_rdata(a_d_rdata), .d_valid(a_d_valid),
        .ram_en(a_ram_en), .ram_we(a_ram_we), .ram_addr(a_ram_addr), .ram_wdata(a_ram_wdata),
        .ram_rdata(a_ram_rdata), .busy(a_busy), .err(a_err)
    );

    // ---------------- instance B, LAT=3 ----------------
    logic        b_rstn, b_if_req, b_d_req, b_d_we, b_if_valid, b_d_valid;
    logic [4:0]  b_if_addr, b_ram_addr;
    logic [15:0] b_d_addr, b_d_wdata, b_if_rdata, b_d_rdata, b_ram_wdata, b_ram_rdata;
    logic        b_ram_en, b_ram_we, b_busy, b_err;

    mem_arbiter #(.DW(16), .AW(5), .LAT(3)) u_dut_b (
        .Clock(clk), .Resetn(b_rstn),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata), .if_valid(b_if_valid),
        .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
        .d_rdata(b_d_rdata), .d_valid(b_d_valid),
        .ram_en(b_ram_en), .ram_we(b_ram_we), .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata),
        .ram_rdata(b_ram_rdata), .busy(b_busy), .err(b_err)
    );

    // ---------------- RAM models ----------------
    logic        preload;
    logic [15:0] a_mem [32];
    logic [15:0] b_mem [32];
    logic [15:0] b_s0, b_s1, b_s2;

    always @(posedge clk) begin
        if (preload) begin
            a_mem[3] <= 16'hA5A5;
            b_mem[3] <= 16'hC3C3;
        end else if (a_ram_en) begin
            if (a_ram_we) a_mem[a_ram_addr] <= a_ram_wdata;
            else          a_ram_rdata       <= a_mem[a_ram_addr];
        end
        if (!preload && b_ram_en) begin
            if (b_ram_we) b_mem[b_ram_addr] <= b_ram_wdata;
            else          b_s0              <= b_mem[b_ram_addr];
        end
        b_s1 <= b_s0;
        b_s2 <= b_s1;
    end
    assign b_ram_rdata = b_s2;

    // ---------------- scoreboard ----------------
    exp_t a_q[$];
    exp_t b_q[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic sb_a(input logic port, input logic [15:0] data);
        exp_t e;
        if (a_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL a_unexpected_valid: port %0d data %0h with empty queue at %0t", port, data, $time);
        end else begin
            e = a_q.pop_front();
            check("a_port", 32'(port), 32'(e.port));
            if (e.chk) check("a_rdata", 32'(data), 32'(e.data));
        end
    endtask

    task automatic sb_b(input logic port, input logic [15:0] data);
        exp_t e;
        if (b_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL b_unexpected_valid: port %0d data %0h with empty queue at %0t", port, data, $time);
        end else begin
            e = b_q.pop_front();
            check("b_port", 32'(port), 32'(e.port));
            if (e.chk) check("b_rdata", 32'(data), 32'(e.data));
        end
    endtask

    // Monitor: pops one expectation per valid pulse.
    always @(negedge clk) begin
        if (a_rstn) begin
            if (a_if_valid) sb_a(PORT_IF, a_if_rdata);
            if (a_d_valid)  sb_a(PORT_D,  a_d_rdata);
        end
        if (b_rstn) begin
            if (b_if_valid) sb_b(PORT_IF, b_if_rdata);
            if (b_d_valid)  sb_b(PORT_D,  b_d_rdata);
        end
    end

    // One transaction on A; called #1 after a rising edge (that cycle is cycle 0).
    task automatic a_txn(input string nm, input logic port, input logic we,
                         input logic [15:0] addr, input logic [15:0] wdata,
                         input logic [15:0] exp_data, input int exp_cyc,
                         output int en_cnt, output int we_cnt, output int other_cnt);
        exp_t e;
        int   n;
        bit   got;
        e.port = port; e.chk = !we; e.data = exp_data;
        a_q.push_back(e);
        if (port == PORT_IF) begin
            a_if_req = 1'b1; a_if_addr = addr[4:0];
        end else begin
            a_d_req = 1'b1; a_d_we = we; a_d_addr = addr; a_d_wdata = wdata;
        end
        n = 0; got = 0; en_cnt = 0; we_cnt = 0; other_cnt = 0;
        while (!got && n < 20) begin
            @(negedge clk);
            en_cnt += int'(a_ram_en);
            we_cnt += int'(a_ram_we);
            if (port == PORT_IF) begin
                other_cnt += int'(a_d_valid);
                if (a_if_valid) got = 1; else n++;
            end else begin
                other_cnt += int'(a_if_valid);
                if (a_d_valid) got = 1; else n++;
            end
        end
        a_if_req = 1'b0;
        a_d_req  = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: no valid within 20 cycles", nm);
        end else begin
            check({nm, "_latency"}, 32'(n), 32'(exp_cyc));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int en_c, we_c, oth_c, vcnt, n;
        bit got;
        exp_t e;

        a_rstn = 1'b0; b_rstn = 1'b0; preload = 1'b1;
        a_if_req = 0; a_if_addr = '0; a_d_req = 0; a_d_we = 0; a_d_addr = '0; a_d_wdata = '0;
        b_if_req = 0; b_if_addr = '0; b_d_req = 0; b_d_we = 0; b_d_addr = '0; b_d_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",   32'(a_busy),   32'd0);
        check("rst_err",    32'(a_err),    32'd0);
        check("rst_valids", 32'({a_if_valid, a_d_valid}), 32'd0);
        check("rst_ram",    32'({a_ram_en, a_ram_we}),    32'd0);
        preload = 1'b0;
        a_rstn = 1'b1; b_rstn = 1'b1;
        @(posedge clk);
        #1;

        // Fetch at addr 3 with LAT=1: valid in cycle 3 only, data port untouched.
        a_txn("fetch", PORT_IF, 1'b0, 16'd3, 16'd0, 16'hA5A5, 3, en_c, we_c, oth_c);
        check("fetch_d_valid_cnt", 32'(oth_c), 32'd0);
        check("fetch_ram_en_cnt",  32'(en_c),  32'd1);

        // Store then load at addr 7.
        a_txn("store", PORT_D, 1'b1, 16'd7, 16'h1234, 16'h0000, 2, en_c, we_c, oth_c);
        check("store_ram_we_cnt", 32'(we_c), 32'd1);
        a_txn("load", PORT_D, 1'b0, 16'd7, 16'd0, 16'h1234, 3, en_c, we_c, oth_c);
        check("load_ram_we_cnt", 32'(we_c), 32'd0);

        // Out-of-range load: no RAM access, returns 0, sticky err; fetch data held.
        a_txn("oor", PORT_D, 1'b0, 16'h0020, 16'd0, 16'h0000, 3, en_c, we_c, oth_c);
        check("oor_ram_en_cnt", 32'(en_c), 32'd0);
        check("oor_err",        32'(a_err), 32'd1);
        check("oor_d_rdata",    32'(a_d_rdata), 32'd0);
        check("if_rdata_hold",  32'(a_if_rdata), 32'hA5A5);

        // Both ports requesting continuously: IF, D, IF, D (last grant was D).
        for (int i = 0; i < 4; i++) begin
            e.port = (i % 2 == 0) ? PORT_IF : PORT_D;
            e.chk  = 1'b1;
            e.data = (i % 2 == 0) ? 16'hA5A5 : 16'h1234;
            a_q.push_back(e);
        end
        a_if_req = 1'b1; a_if_addr = 5'd3;
        a_d_req = 1'b1; a_d_we = 1'b0; a_d_addr = 16'd7;
        vcnt = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            check("rr_busy", 32'(a_busy), 32'((c % 4) != 0));
            vcnt += int'(a_if_valid) + int'(a_d_valid);
        end
        a_if_req = 1'b0; a_d_req = 1'b0;
        check("rr_valid_cnt", 32'(vcnt), 32'd4);
        check("err_sticky",   32'(a_err), 32'd1);
        @(posedge clk);
        #1;

        // LAT=3 fetch on B: valid in cycle 5.
        e.port = PORT_IF; e.chk = 1'b1; e.data = 16'hC3C3;
        b_q.push_back(e);
        b_if_req = 1'b1; b_if_addr = 5'd3;
        n = 0; got = 0;
        while (!got && n < 20) begin
            @(negedge clk);
            if (b_if_valid) got = 1; else n++;
        end
        b_if_req = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL lat3_timeout: no if_valid within 20 cycles");
        end else begin
            check("lat3_latency", 32'(n), 32'd5);
        end
        @(posedge clk);
        #1;

        // Second fetch, reset during WAIT (cycle 2): everything clears, no valid afterwards.
        b_if_req = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("lat3_busy_before_rst", 32'(b_busy), 32'd1);
        b_rstn = 1'b0;
        b_if_req = 1'b0;
        #1;
        check("midrst_busy",     32'(b_busy),     32'd0);
        check("midrst_if_rdata", 32'(b_if_rdata), 32'd0);
        check("midrst_outs",     32'({b_if_valid, b_d_valid, b_ram_en, b_ram_we, b_err}), 32'd0);
        check("midrst_d_rdata",  32'(b_d_rdata),  32'd0);
        repeat (2) @(posedge clk);
        #1;
        b_rstn = 1'b1;
        vcnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            vcnt += int'(b_if_valid);
        end
        check("midrst_no_valid", 32'(vcnt), 32'd0);
        check("a_queue_empty", 32'(a_q.size()), 32'd0);
        check("b_queue_empty", 32'(b_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
